// File: rtl/inner_fn_sched.sv
// Streaming scheduler for the fixed-latency inner-function pipeline: credit-gated issue,
// in-order result FIFO with job framing. Optional checker: INNER_FN_SCHED_ERRCHK_EN.
module inner_fn_sched #(
  parameter int LATENCY    = 13,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             pipe_clk_en,
  output logic             pipe_aclr,
  output logic             pipe_start,
  output logic [31:0]      pipe_dataa,
  input  logic             pipe_done,
  input  logic [31:0]      pipe_result,
  output logic             busy,
  output logic [CNT_W-1:0] job_len,
  output logic             err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      fifo_cnt, inflight;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [32:0]        mem [FIFO_DEPTH];
  logic [LATENCY-1:0] last_sr;
  logic               issue, retire, push, pop, full, has_credit;

  // Credit uses registered counters only, so out_ready never reaches in_ready.
  assign has_credit  = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
  assign in_ready    = (state != DRAIN) && has_credit && !flush && !pipe_aclr;
  assign issue       = in_valid && in_ready;
  assign pipe_start  = issue;
  assign pipe_dataa  = in_data;
  assign pipe_clk_en = aclr_n;

  // Completions landing in the flush cycle or the pipeline-clear cycle are discarded.
  assign retire    = pipe_done && !flush && !pipe_aclr;
  assign full      = (fifo_cnt == CW'(FIFO_DEPTH));
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign push      = retire && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr][31:0] : 32'd0;
  assign out_last  = out_valid && mem[rd_ptr][32];
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (issue) state_nxt = in_last ? DRAIN : RUN;
        RUN:     if (issue && in_last) state_nxt = DRAIN;
        DRAIN:   if (pop && out_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      fifo_cnt  <= '0;
      inflight  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_sr   <= '0;
      job_len   <= '0;
      pipe_aclr <= 1'b1;
    end else begin
      pipe_aclr <= flush;
      if (flush) begin
        fifo_cnt <= '0;
        inflight <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        last_sr  <= '0;
      end else begin
        last_sr  <= {last_sr[LATENCY-2:0], issue && in_last};
        inflight <= inflight + CW'(issue) - CW'(retire && (inflight != '0));
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (issue) job_len <= (state == IDLE) ? CNT_W'(1) : job_len + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {last_sr[LATENCY-1], pipe_result};
  end

`ifdef INNER_FN_SCHED_ERRCHK_EN
  logic [LATENCY-1:0] exp_sr;
  logic               err_q, err_hit;

  assign err_hit = !flush && !pipe_aclr &&
                   ((pipe_done != exp_sr[LATENCY-1]) ||
                    (pipe_done && (inflight == '0)) ||
                    (pipe_done && full && !pop));

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      exp_sr <= '0;
      err_q  <= 1'b0;
    end else if (flush) begin
      exp_sr <= '0;
      err_q  <= 1'b0;
    end else begin
      exp_sr <= {exp_sr[LATENCY-2:0], issue};
      if (err_hit) err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_inner_fn_sched.sv
// Directed bench for inner_fn_sched with a behavioural pipeline stub and a result scoreboard.
module tb_inner_fn_sched;
  localparam int LAT = 13;
`ifdef INNER_FN_SCHED_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic        clock, aclr_n, flush, in_valid, in_ready, in_last;
  logic [31:0] in_data, out_data, pipe_dataa, pipe_result;
  logic        out_valid, out_ready, out_last, pipe_clk_en, pipe_aclr, pipe_start, pipe_done;
  logic        busy, err;
  logic [15:0] job_len;

  logic        fn_mode, inj, mon_en;
  logic [32:0] sbq[$];
  logic [32:0] mon_exp;
  int          checks = 0, errors = 0;

  inner_fn_sched #(.LATENCY(LAT), .FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clock(clock), .aclr_n(aclr_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .pipe_clk_en(pipe_clk_en), .pipe_aclr(pipe_aclr), .pipe_start(pipe_start),
    .pipe_dataa(pipe_dataa), .pipe_done(pipe_done), .pipe_result(pipe_result),
    .busy(busy), .job_len(job_len), .err(err));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic real fp2r(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:0] == 31'd0) return 0.0;
    e = 11'(b[30:23]) + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] inner_fn(input logic [31:0] b);
    real x;
    x = fp2r(b);
    return r2fp(0.5 * x + x * x * $cos((x - 128.0) / 128.0));
  endfunction

  // Pipeline stub: fixed latency, either the real function or a +1 tag.
  logic [LAT-1:0] sv;
  logic [31:0]    sd [LAT];
  always @(posedge clock) begin
    if (pipe_aclr) sv <= '0;
    else if (pipe_clk_en) begin
      sv    <= {sv[LAT-2:0], pipe_start};
      sd[0] <= fn_mode ? inner_fn(pipe_dataa) : pipe_dataa + 32'd1;
      for (int i = 1; i < LAT; i++) sd[i] <= sd[i-1];
    end
  end
  assign pipe_done   = sv[LAT-1] | inj;
  assign pipe_result = sd[LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && aclr_n && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
      else begin
        mon_exp = sbq.pop_front();
        chk("sb_result", 64'({out_last, out_data}), 64'(mon_exp));
      end
    end
  end

  // Presents one operand and returns at the negedge where it is seen accepted; in_valid stays high.
  task automatic send(input logic [31:0] d, input logic l, input int budget);
    int k;
    k = 0;
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clock);
    while (!in_ready && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    if (in_ready && mon_en) sbq.push_back({l, d + 32'd1});
  endtask

  task automatic idle();
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    @(negedge clock);
    while ((sbq.size() != 0 || out_valid) && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int n, d, idx;
    aclr_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0; fn_mode = 1'b0; inj = 1'b0; mon_en = 1'b0;

    // Reset values and release sequence
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'({out_last, out_data}), 64'd0);
    chk("rst_pipe_aclr", 64'(pipe_aclr), 64'd1);
    chk("rst_clk_en", 64'(pipe_clk_en), 64'd0);
    chk("rst_busy_err", 64'({busy, err, pipe_start}), 64'd0);
    chk("rst_job_len", 64'(job_len), 64'd0);
    @(posedge clock); #1; aclr_n = 1'b1;
    @(negedge clock);
    chk("rel_pipe_aclr", 64'(pipe_aclr), 64'd1);
    chk("rel_clk_en", 64'(pipe_clk_en), 64'd1);
    chk("rel_in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    chk("run_pipe_aclr", 64'(pipe_aclr), 64'd0);
    chk("run_in_ready", 64'(in_ready), 64'd1);

    // Single operand through the real function
    fn_mode = 1'b1;
    send(32'h43000000, 1'b1, 4);
    chk("fn_start", 64'(pipe_start), 64'd1);
    idle();
    @(negedge clock);
    chk("fn_start_pulse", 64'(pipe_start), 64'd0);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("fn_latency", 64'(n), 64'd14);
    d = int'(out_data) - int'(32'h46808000);
    chk("fn_ulp", 64'(d <= 2 && d >= -2), 64'd1);
    chk("fn_last", 64'(out_last), 64'd1);
    chk("fn_job_len", 64'(job_len), 64'd1);
    chk("fn_busy", 64'(busy), 64'd1);
    @(posedge clock); #1; out_ready = 1'b1;
    @(posedge clock); #1; out_ready = 1'b0; fn_mode = 1'b0;
    @(negedge clock);
    chk("fn_busy_done", 64'({busy, out_valid}), 64'd0);

    // Full-rate burst of 20
    mon_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(32'h1000 + 32'(i), i == 19, 0);
    idle();
    wait_drain(100);
    chk("burst_job_len", 64'(job_len), 64'd20);
    chk("burst_busy", 64'(busy), 64'd0);

    // Backpressure: 40 offered, credits stop at 16
    @(posedge clock); #1; out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      in_valid = 1'b1; in_data = 32'h2000 + 32'(idx); in_last = (idx == 39);
      @(negedge clock);
      if (in_ready) begin sbq.push_back({in_last, in_data + 32'd1}); idx++; end
    end
    chk("bp_accepted", 64'(idx), 64'd16);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    n = 0;
    while (idx < 40 && n < 300) begin
      @(posedge clock); #1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h2000 + 32'(idx); in_last = (idx == 39);
      @(negedge clock);
      if (in_ready) begin sbq.push_back({in_last, in_data + 32'd1}); idx++; end
      n++;
    end
    chk("bp_all_accepted", 64'(idx), 64'd40);
    idle();
    wait_drain(300);
    chk("bp_job_len", 64'(job_len), 64'd40);
    chk("bp_err", 64'(err), 64'd0);

    // Flush five operands into a ten-operand job
    for (int i = 0; i < 5; i++) send(32'h3000 + 32'(i), 1'b0, 0);
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clock);
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    sbq.delete();
    @(posedge clock); #1; flush = 1'b0;
    @(negedge clock);
    chk("fl_pipe_aclr", 64'(pipe_aclr), 64'd1);
    chk("fl_in_ready2", 64'(in_ready), 64'd0);
    chk("fl_out_busy", 64'({out_valid, busy}), 64'd0);
    @(negedge clock);
    chk("fl_pipe_aclr_end", 64'(pipe_aclr), 64'd0);
    repeat (20) @(negedge clock);
    for (int i = 0; i < 3; i++) send(32'h4000 + 32'(i), i == 2, 4);
    idle();
    wait_drain(100);
    chk("fl_job_len", 64'(job_len), 64'd3);
    chk("fl_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a job
    for (int i = 0; i < 8; i++) send(32'h5000 + 32'(i), 1'b0, 0);
    @(posedge clock); #3; aclr_n = 1'b0;
    #1;
    chk("mr_pipe_start", 64'(pipe_start), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    chk("mr_outs", 64'({out_valid, out_last, out_data}), 64'd0);
    chk("mr_pipe", 64'({pipe_aclr, pipe_clk_en}), 64'd2);
    chk("mr_busy_len", 64'({busy, job_len}), 64'd0);
    sbq.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1; aclr_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("mr_quiet", 64'({out_valid, busy}), 64'd0);

    // Spurious completion with nothing in flight
    mon_en = 1'b0; out_ready = 1'b0;
    @(posedge clock); #1; inj = 1'b1;
    @(posedge clock); #1; inj = 1'b0;
    @(negedge clock);
    chk("ec_err_set", 64'(err), 64'(ERRCHK));
    repeat (3) @(negedge clock);
    chk("ec_err_hold", 64'(err), 64'(ERRCHK));
    @(posedge clock); #1; flush = 1'b1;
    @(posedge clock); #1; flush = 1'b0;
    @(negedge clock);
    chk("ec_err_clr", 64'(err), 64'd0);
    chk("ec_fifo_clr", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
